// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and parity helper, reused by the transmitter and receiver.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  localparam int MAX_DATA_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SYNC   = ST_SYNC,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } uart_state_e;

  // Zero-extended payloads are safe here: padding zeros do not change the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: frames a latched payload as start, data (LSB first), optional parity and stop bits,
// advancing one bit per baud_tick from the shared baud tick generator.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int                CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          shift_d   = tx_data;
          par_en_d  = parity_en;
          par_bit_d = parity_bit(MAX_DATA_BITS'(tx_data), parity_odd);
          busy_d    = 1'b1;
          state_d   = S_SYNC;
        end
      end
      // Waiting for a tick before the start bit keeps the start bit a full baud period long.
      S_SYNC: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == BIT_LAST) begin
            if (par_en_q) begin
              tx_d    = par_bit_q;
              state_d = S_PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = S_STOP;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, sets the number of data bits per frame (5..8).
REQ-002 Parameter STOP_BITS, default 1, sets the number of stop bits per frame (1 or 2).
REQ-003 clk  input  1  the single system clock; all logic SHALL be on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 baud_tick  input  1  one-clk pulse per bit period, from the baud tick generator.
REQ-006 tx_start  input  1  request to send tx_data; level-sampled each clk.
REQ-007 tx_data  input  DATA_BITS  frame payload, sent LSB first.
REQ-008 parity_en  input  1  1 = insert a parity bit after the data bits.
REQ-009 parity_odd  input  1  1 = odd parity, 0 = even parity; ignored when parity_en=0.
REQ-010 tx  output  1  serial line, registered, idle high.
REQ-011 tx_busy  output  1  high while a frame is in progress.
REQ-012 tx_done  output  1  one-clk pulse when the last stop bit period completes.

Function
REQ-013 The block SHALL be a FSM with states IDLE, SYNC, START, DATA, PARITY, STOP.
REQ-014 In IDLE with tx_start=1, the block SHALL latch tx_data, parity_en and parity_odd, go to SYNC, and assert tx_busy on the next clk.
REQ-015 In SYNC, the block SHALL keep tx=1 until the first baud_tick, then drive tx=0 and go to START, so that every bit lasts exactly one full baud period.
REQ-016 In START on baud_tick, the block SHALL drive tx=data[0], clear bit_cnt, and go to DATA.
REQ-017 In DATA on baud_tick with bit_cnt<DATA_BITS-1, the block SHALL drive the next data bit and increment bit_cnt.
REQ-018 In DATA on baud_tick with bit_cnt=DATA_BITS-1, the block SHALL go to PARITY (tx=parity bit) if parity_en is latched; otherwise it SHALL go to STOP (tx=1).
REQ-019 The parity bit SHALL be the XOR of the latched data bits for even parity and its inverse for odd parity.
REQ-020 In PARITY on baud_tick, the block SHALL drive tx=1, clear stop_cnt, and go to STOP.
REQ-021 In STOP on baud_tick with stop_cnt<STOP_BITS-1, the block SHALL increment stop_cnt and hold tx=1.
REQ-022 In STOP on baud_tick with stop_cnt=STOP_BITS-1, the block SHALL go to IDLE, pulse tx_done for one clk, and deassert tx_busy in the same clk.
REQ-023 The FSM SHALL advance only on baud_tick; between ticks, all state, counters and tx SHALL hold.
REQ-024 tx_start while not in IDLE SHALL be ignored, and the latched data SHALL be unaffected.
REQ-025 tx_start asserted in the clk where tx_done=1 (state already IDLE) SHALL be accepted, giving back-to-back frames.
REQ-026 A baud_tick coinciding with tx_start in IDLE SHALL NOT advance SYNC; the frame waits for the next tick.
REQ-027 A frame's tx waveform SHALL be 1 start + DATA_BITS + parity_en + STOP_BITS bit periods, each exactly one tick interval.

Reset
REQ-028 rst=1 SHALL force state=IDLE, tx=1, tx_busy=0, tx_done=0, and clear counters and latched data on the next clk edge.
REQ-029 rst asserted mid-frame SHALL abort the frame with no tx_done pulse; tx SHALL be 1 from the following clk.
REQ-030 rst SHALL take priority over tx_start and baud_tick.

Structure
REQ-031 State encodings SHALL be shared localparams in the common UART header/package, for reuse by the receiver.
REQ-032 The block SHALL have no sub-modules; it consumes baud_tick from the existing baud tick generator instantiated at top level.

Verification (bench baud_tick every 4 clk, DATA_BITS=8)
REQ-033 tx_data=0x55, parity_en=0, STOP_BITS=1 -> after first tick, tx sequence SHALL be 0,1,0,1,0,1,0,1,0,1, each held 4 clk, and tx_done SHALL pulse once after 10 periods.
REQ-034 tx_data=0xA5, parity_en=1, parity_odd=0 -> parity bit SHALL be 0; with parity_odd=1 it SHALL be 1; frame length SHALL be 11 periods.
REQ-035 STOP_BITS=2, tx_data=0xFF -> tx SHALL be high for 2 full periods after the data bits before tx_done.
REQ-036 tx_start=1 with 0x12 during a frame of 0x34 -> 0x34 SHALL be sent unchanged and 0x12 dropped; tx_start held through tx_done SHALL start the next frame immediately.
REQ-037 rst pulsed during bit 3 of a frame -> tx=1, tx_busy=0 next clk, no tx_done, and a new tx_start SHALL produce a clean full frame.
